// File: rtl/perf_report_serializer.sv
// perf_report_serializer
// Snapshots the performance meter's total_cycles / instr_count / cpi on request
// and streams them as a 14-byte frame (header, 12 payload bytes MSB first,
// XOR checksum) over a byte-wide valid/ready interface. All outputs are
// registered; the snapshot is frozen for the whole frame.
module perf_report_serializer #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snap_req,
  input  logic [31:0] total_cycles,
  input  logic [31:0] instr_count,
  input  logic [31:0] cpi,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state_r;
  logic [3:0]  idx_r;
  logic [95:0] snap_r;
  logic [7:0]  csum_r;
  logic [7:0]  tx_data_r;
  logic        tx_valid_r;
  logic        busy_r;
  logic        frame_done_r;
  logic        overrun_r;

  logic        accept_s;
  logic        last_s;
  logic [95:0] live_s;

  // XOR of the twelve payload bytes; evaluated on the live inputs so the
  // checksum is ready at the same edge the snapshot is taken.
  function automatic logic [7:0] xor_bytes(input logic [95:0] v);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 12; i++) begin
      acc = acc ^ v[i*8 +: 8];
    end
    return acc;
  endfunction

  // Frame byte at a given index: header, 12 snapshot bytes MSB first, checksum.
  function automatic logic [7:0] frame_byte(input logic [95:0] snap,
                                            input logic [7:0]  csum,
                                            input logic [3:0]  idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = HEADER;
      4'd1:    b = snap[95:88];
      4'd2:    b = snap[87:80];
      4'd3:    b = snap[79:72];
      4'd4:    b = snap[71:64];
      4'd5:    b = snap[63:56];
      4'd6:    b = snap[55:48];
      4'd7:    b = snap[47:40];
      4'd8:    b = snap[39:32];
      4'd9:    b = snap[31:24];
      4'd10:   b = snap[23:16];
      4'd11:   b = snap[15:8];
      4'd12:   b = snap[7:0];
      4'd13:   b = csum;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign accept_s = tx_valid_r & tx_ready;
  assign last_s   = (idx_r == 4'd13);
  assign live_s   = {total_cycles, instr_count, cpi};

  // Frame sequencer: snapshot on request, advance one byte per accept,
  // flag requests that arrive while a frame is draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      idx_r        <= 4'd0;
      snap_r       <= 96'd0;
      csum_r       <= 8'h00;
      tx_data_r    <= 8'h00;
      tx_valid_r   <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          frame_done_r <= 1'b0;
          if (snap_req) begin
            state_r    <= SEND;
            snap_r     <= live_s;
            csum_r     <= xor_bytes(live_s);
            idx_r      <= 4'd0;
            overrun_r  <= 1'b0;
            tx_data_r  <= HEADER;
            tx_valid_r <= 1'b1;
            busy_r     <= 1'b1;
          end else begin
            state_r    <= IDLE;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
          end
        end
        SEND: begin
          // A request during a frame is never queued, only recorded.
          if (snap_req) begin
            overrun_r <= 1'b1;
          end else begin
            overrun_r <= overrun_r;
          end
          if (accept_s && last_s) begin
            state_r      <= IDLE;
            idx_r        <= 4'd0;
            tx_data_r    <= 8'h00;
            tx_valid_r   <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b1;
          end else if (accept_s) begin
            idx_r        <= idx_r + 4'd1;
            tx_data_r    <= frame_byte(snap_r, csum_r, idx_r + 4'd1);
            frame_done_r <= 1'b0;
          end else begin
            // Stalled by the sink: byte and index hold.
            frame_done_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          idx_r        <= 4'd0;
          tx_data_r    <= 8'h00;
          tx_valid_r   <= 1'b0;
          busy_r       <= 1'b0;
          frame_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data    = tx_data_r;
  assign tx_valid   = tx_valid_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_perf_report_serializer.sv
// Testbench for perf_report_serializer: table of frames applied in a loop,
// expected bytes pushed to a scoreboard queue at request time and popped as
// the sink accepts them.
module tb_perf_report_serializer;

  logic        clk;
  logic        rst_n;
  logic        snap_req;
  logic [31:0] total_cycles;
  logic [31:0] instr_count;
  logic [31:0] cpi;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  perf_report_serializer #(.HEADER(8'hA5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .snap_req     (snap_req),
    .total_cycles (total_cycles),
    .instr_count  (instr_count),
    .cpi          (cpi),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tc;
    logic [31:0] ic;
    logic [31:0] cp;
    bit          bp;     // tx_ready pattern 1,0,0,1,...
    bit          inc;    // total_cycles keeps counting during the frame
    bit          ovr;    // snap_req at idx 5 and at final accept
    bit          abort;  // reset at idx 7
    logic [7:0]  csum;   // hand-computed checksum
  } frame_vec_t;

  frame_vec_t  vecs[7];
  logic [7:0]  exp_q[$];
  int          n_checks;
  int          n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [31:0] tc, input logic [31:0] ic, input logic [31:0] cp);
    logic [95:0] p;
    logic [7:0]  c;
    logic [7:0]  b;
    p = {tc, ic, cp};
    c = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 12; i++) begin
      b = p[95 - 8*i -: 8];
      exp_q.push_back(b);
      c = c ^ b;
    end
    exp_q.push_back(c);
  endtask

  // Entered and left at a negedge; snap_req is sampled on the next posedge.
  task automatic run_frame(input frame_vec_t v);
    int         cyc;
    int         acc;
    bit         stall_prev;
    logic [7:0] prev;
    logic       rdy;
    logic [7:0] e;
    total_cycles = v.tc;
    instr_count  = v.ic;
    cpi          = v.cp;
    snap_req     = 1'b1;
    push_frame(v.tc, v.ic, v.cp);
    cyc = 0;
    acc = 0;
    stall_prev = 1'b0;
    prev = 8'h00;
    while (acc < 14 && cyc < 80) begin
      @(negedge clk);
      if (v.inc) total_cycles = total_cycles + 32'd1;
      if (cyc == 0) begin
        chk("hdr_valid", {31'd0, tx_valid}, 32'd1);
        chk("hdr_data", {24'd0, tx_data}, 32'hA5);
        chk("ovr_cleared", {31'd0, overrun}, 32'd0);
        chk("done_low", {31'd0, frame_done}, 32'd0);
      end
      chk("busy_eq_valid", {31'd0, busy}, {31'd0, tx_valid});
      if (stall_prev) chk("stall_hold", {24'd0, tx_data}, {24'd0, prev});
      if (v.ovr && acc == 7) chk("ovr_mid", {31'd0, overrun}, 32'd1);
      if (v.abort && acc == 7) begin
        rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        snap_req = 1'b0;
        tx_ready = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("no_resume", {31'd0, busy}, 32'd0);
        return;
      end
      rdy = v.bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      tx_ready = rdy;
      snap_req = v.ovr && tx_valid && (acc == 5 || acc == 13);
      if (tx_valid && rdy) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("byte", {24'd0, tx_data}, {24'd0, e});
        end
        if (acc == 13) chk("csum", {24'd0, tx_data}, {24'd0, v.csum});
        acc++;
      end
      stall_prev = tx_valid && !rdy;
      prev = tx_data;
      cyc++;
    end
    if (acc != 14) chk("frame_timeout", acc, 32'd14);
    if (!v.bp) chk("frame_cycles", cyc, 32'd14);
    @(negedge clk);
    snap_req = 1'b0;
    tx_ready = 1'b1;
    chk("done_pulse", {31'd0, frame_done}, 32'd1);
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("valid_end", {31'd0, tx_valid}, 32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);
    if (v.ovr) chk("ovr_sticky", {31'd0, overrun}, 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    vecs[0] = '{32'd100, 32'd10, 32'd10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h64};
    vecs[1] = '{32'd100, 32'd10, 32'd10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h64};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{32'h12345678, 32'h9ABCDEF0, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
    vecs[4] = '{32'h01020304, 32'h10203040, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44};
    vecs[5] = '{32'd100, 32'd10, 32'd10, 1'b0, 1'b0, 1'b0, 1'b1, 8'h64};
    vecs[6] = '{32'd100, 32'd10, 32'd10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h64};

    rst_n        = 1'b0;
    snap_req     = 1'b0;
    total_cycles = 32'd0;
    instr_count  = 32'd0;
    cpi          = 32'd0;
    tx_ready     = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data", {24'd0, tx_data}, 32'd0);
    chk("reset_valid", {31'd0, tx_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, frame_done}, 32'd0);
    chk("reset_ovr", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_valid", {31'd0, tx_valid}, 32'd0);

    // Frames run back to back: each new request is sampled on the edge right
    // after the previous frame_done edge, the earliest legal restart.
    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i]);
    end
    @(negedge clk);
    chk("final_done_low", {31'd0, frame_done}, 32'd0);
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_report_serializer.md
# perf_report_serializer

Downstream consumer of the performance meter's `total_cycles`, `instr_count` and `cpi` outputs. On request, it snapshots all three 32-bit values and streams them as a fixed 14-byte frame over a byte-wide valid/ready interface, for a UART or debug port. The frame is a header byte, 12 payload bytes and an XOR checksum. The snapshot is atomic, so the counters can keep running while the frame drains.

## Interface
Parameters:
- `HEADER`, default 8'hA5: first byte of every frame.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `snap_req`  in  1  level sampled each cycle; starts a frame when idle.
- `total_cycles`  in  32  cycle count from the meter.
- `instr_count`  in  32  instruction count from the meter.
- `cpi`  in  32  CPI value from the meter.
- `tx_data`  out  8  current frame byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the byte when `tx_valid && tx_ready`.
- `busy`  out  1  a frame is in progress.
- `frame_done`  out  1  one-cycle pulse after the last byte is accepted.
- `overrun`  out  1  sticky flag: `snap_req` was seen while busy.

## Operation
- States: IDLE, SEND. Byte index `idx` is 4 bits, range 0..13.
- IDLE → SEND when `snap_req`=1:
  - Latch `total_cycles`, `instr_count` and `cpi` into a 96-bit snapshot.
  - Compute checksum = XOR of the 12 snapshot bytes.
  - Set `idx`=0 and clear `overrun`.
- Frame order, MSB first within each word:
  - idx 0: `HEADER`.
  - idx 1-4: `total_cycles[31:24]` .. `[7:0]`.
  - idx 5-8: `instr_count`, same byte order.
  - idx 9-12: `cpi`, same byte order.
  - idx 13: checksum.
- In SEND, `tx_valid`=1 and `tx_data` = byte[idx].
- On accept: if `idx`<13, `idx`++. If `idx`==13, go to IDLE and pulse `frame_done`.
- Backpressure: while `tx_valid && !tx_ready`, `tx_data` and `idx` hold stable. `tx_valid` never drops mid-frame.
- Inputs are ignored after the snapshot. Frame content is fixed at the request edge.
- `snap_req`=1 while in SEND sets `overrun`=1 and does not restart or queue a frame. This includes the cycle in which the last byte is accepted.
- `busy` = (state==SEND). `tx_valid` equals `busy`.

## Timing
- Reset values: `tx_data`=0, `tx_valid`=0, `busy`=0, `frame_done`=0, `overrun`=0, state IDLE, `idx`=0, snapshot=0.
- Reset asserted mid-frame clears all outputs immediately (asynchronous). The partial frame is abandoned, not resumed.
- `snap_req` sampled high at edge N:
  - After edge N: `tx_valid`=1 and `tx_data`=`HEADER`.
  - The checksum is available from edge N; no extra cycle is spent computing it.
- With `tx_ready` tied high, the frame occupies exactly 14 cycles.
  - Last accept at edge N+14.
  - After N+14: `busy`=0 and `frame_done`=1 for one cycle.
- Earliest next frame: `snap_req` sampled at edge N+15.
- All outputs are registered. There is no combinational path from `tx_ready` or `snap_req` to any output.

## Test plan
- Basic frame: `total_cycles`=100, `instr_count`=10, `cpi`=10, `tx_ready`=1, pulse `snap_req` → bytes A5 00 00 00 64 00 00 00 0A 00 00 00 0A 64 on 14 consecutive cycles; `frame_done` pulses once.
- Atomic snapshot: `total_cycles` increments every cycle during the frame → bytes 1-4 equal the value at the request edge; checksum matches the sent payload.
- Backpressure: `tx_ready` toggled 1,0,0,1,... → each byte appears exactly once at the sink, `tx_data` is stable while stalled, and the sequence is the same as the basic frame.
- Overrun: `snap_req` at idx 5 and again on the final-accept cycle → one frame only; `overrun`=1 until the next accepted `snap_req`, then 0.
- Reset mid-frame: `rst_n`=0 at idx 7 → `tx_valid`, `busy` and `tx_data` are 0 immediately; after release, a new `snap_req` yields a complete frame starting with A5.
- Checksum corner: all inputs 32'hFFFFFFFF → 12 payload bytes of FF, checksum 00.
